// File: rtl/srl_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_ctrl_if
//  Description : Write port, valid/ready read port and status for srl_fifo_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface srl_fifo_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             WR_EN;
  logic [WIDTH-1:0] WR_DATA;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             OVERFLOW;
  logic             RD_VALID;
  logic             RD_READY;
  logic [WIDTH-1:0] RD_DATA;
  logic [5:0]       LEVEL;

  // master: producer/consumer side; slave: the FIFO controller
  modport master (
    output WR_EN, WR_DATA, RD_READY,
    input  FULL, ALMOST_FULL, OVERFLOW, RD_VALID, RD_DATA, LEVEL
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_READY,
    output FULL, ALMOST_FULL, OVERFLOW, RD_VALID, RD_DATA, LEVEL
  );
endinterface
`default_nettype wire

// File: rtl/srl_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_ctrl
//  Description : 33-entry FIFO: 32-deep per-bit shift registers plus one
//                registered output stage with a valid/ready read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = 28
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  srl_fifo_ctrl_if.slave    bus
);

  localparam logic [5:0] c_SRL_DEPTH = 6'd32;
  localparam logic [5:0] c_AF_LEVEL  = 6'(AF_THRESH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t           r_state;
  logic [5:0]       r_srl_cnt;
  logic [WIDTH-1:0] r_out_q;
  logic             r_ovf;

  logic [4:0]       w_tap;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_has_data;
  logic             w_pop;
  logic             w_out_vld;
  logic [WIDTH-1:0] w_srl_q;

  // The tap trails the count by one so it always addresses the oldest word.
  assign w_tap      = r_srl_cnt[4:0] - 5'd1;
  assign w_full     = (r_srl_cnt == c_SRL_DEPTH);
  assign w_wr_acc   = bus.WR_EN & ~w_full;
  assign w_has_data = (r_srl_cnt != 6'd0);
  assign w_out_vld  = (r_state == ST_VALID);
  assign w_pop      = w_has_data & (~w_out_vld | bus.RD_READY);

  // One addressable shift register per data bit, mapping onto an SRLC32E.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [31:0] r_sr;

      always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
          r_sr <= {r_sr[30:0], bus.WR_DATA[gi]};
        end
      end

      assign w_srl_q[gi] = r_sr[w_tap];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_EMPTY;
      r_srl_cnt <= 6'd0;
      r_ovf     <= 1'b0;
    end else begin
      if (bus.WR_EN & w_full) begin
        r_ovf <= 1'b1;
      end

      if (w_wr_acc & ~w_pop) begin
        r_srl_cnt <= r_srl_cnt + 6'd1;
      end else if (w_pop & ~w_wr_acc) begin
        r_srl_cnt <= r_srl_cnt - 6'd1;
      end

      // Q is read at the pre-shift tap, so a same-edge write cannot disturb the pop.
      case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            r_out_q <= w_srl_q;
            r_state <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (bus.RD_READY) begin
            if (w_pop) begin
              r_out_q <= w_srl_q;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.FULL        = w_full;
  assign bus.ALMOST_FULL = (r_srl_cnt >= c_AF_LEVEL);
  assign bus.OVERFLOW    = r_ovf;
  assign bus.RD_VALID    = w_out_vld;
  assign bus.RD_DATA     = r_out_q;
  assign bus.LEVEL       = r_srl_cnt + {5'd0, w_out_vld};

endmodule
`default_nettype wire

// File: tb/tb_srl_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srl_fifo_ctrl
//  Description : Self-checking bench for srl_fifo_ctrl against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_fifo_ctrl;

  localparam int c_WIDTH = 8;
  localparam int c_AF    = 28;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  // Reference model: words waiting behind the output stage, plus the stage itself
  logic [c_WIDTH-1:0] m_q[$];
  logic               m_vld = 1'b0;
  logic [c_WIDTH-1:0] m_out = '0;
  logic               m_ovf = 1'b0;

  srl_fifo_ctrl_if #(.WIDTH(c_WIDTH)) bus ();

  srl_fifo_ctrl #(.WIDTH(c_WIDTH), .AF_THRESH(c_AF)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the model from the sampled inputs, settle.
  task automatic tick();
    bit full;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
    end else begin
      full = (m_q.size() == 32);
      if (bus.WR_EN && full) m_ovf = 1'b1;
      if (m_q.size() > 0 && (!m_vld || bus.RD_READY)) begin
        m_out = m_q.pop_front();
        m_vld = 1'b1;
      end else if (m_vld && bus.RD_READY) begin
        m_vld = 1'b0;
      end
      if (bus.WR_EN && !full) m_q.push_back(bus.WR_DATA);
    end
    #1;
  endtask

  task automatic idle();
    bus.WR_EN    = 1'b0;
    bus.RD_READY = 1'b0;
    bus.WR_DATA  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 60; i++) begin
      bus.WR_EN    = ($urandom_range(0, 3) != 0);
      bus.WR_DATA  = c_WIDTH'($urandom);
      bus.RD_READY = ($urandom_range(0, 3) == 0);
      tick();
      n_run++;
      if (bus.LEVEL !== 6'(m_q.size() + int'(m_vld))) begin
        n_fail++;
        $display("FAIL reset_prelude_level cyc=%0d got=%0d exp=%0d", i, bus.LEVEL, m_q.size() + int'(m_vld));
      end
    end
    bus.WR_EN = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_run++;
    if (bus.LEVEL !== 6'd0 || bus.RD_VALID !== 1'b0 || bus.FULL !== 1'b0 ||
        bus.OVERFLOW !== 1'b0 || bus.ALMOST_FULL !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got lvl=%0d vld=%b full=%b ovf=%b af=%b exp 0/0/0/0/0",
               bus.LEVEL, bus.RD_VALID, bus.FULL, bus.OVERFLOW, bus.ALMOST_FULL);
    end
  endtask

  task automatic test_latency();
    do_reset();
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = 8'hA5;
    tick();
    idle();
    n_run++;
    if (bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd1) begin
      n_fail++;
      $display("FAIL latency_edge1 got vld=%b lvl=%0d exp vld=0 lvl=1", bus.RD_VALID, bus.LEVEL);
    end
    tick();
    n_run++;
    if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 8'hA5 || bus.LEVEL !== 6'd1) begin
      n_fail++;
      $display("FAIL latency_edge2 got vld=%b data=%h lvl=%0d exp vld=1 data=a5 lvl=1",
               bus.RD_VALID, bus.RD_DATA, bus.LEVEL);
    end
    bus.RD_READY = 1'b1;
    tick();
    idle();
    n_run++;
    if (bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd0) begin
      n_fail++;
      $display("FAIL latency_drain got vld=%b lvl=%0d exp vld=0 lvl=0", bus.RD_VALID, bus.LEVEL);
    end
  endtask

  task automatic test_fill_drain();
    int exp_word;
    do_reset();
    for (int i = 0; i <= 8'h22; i++) begin
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 8'(i);
      tick();
      n_run++;
      if (bus.LEVEL !== 6'(m_q.size() + int'(m_vld)) ||
          bus.FULL !== (m_q.size() == 32) ||
          bus.ALMOST_FULL !== (m_q.size() >= c_AF) ||
          bus.OVERFLOW !== m_ovf) begin
        n_fail++;
        $display("FAIL fill_flags w=%0d got lvl=%0d full=%b af=%b ovf=%b exp lvl=%0d full=%b af=%b ovf=%b",
                 i, bus.LEVEL, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW,
                 m_q.size() + int'(m_vld), m_q.size() == 32, m_q.size() >= c_AF, m_ovf);
      end
    end
    idle();
    n_run++;
    if (bus.LEVEL !== 6'd33 || bus.FULL !== 1'b1 || bus.OVERFLOW !== 1'b1 || bus.ALMOST_FULL !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_end got lvl=%0d full=%b ovf=%b af=%b exp 33/1/1/1",
               bus.LEVEL, bus.FULL, bus.OVERFLOW, bus.ALMOST_FULL);
    end
    exp_word = 0;
    bus.RD_READY = 1'b1;
    for (int c = 0; c < 60 && bus.RD_VALID === 1'b1; c++) begin
      n_run++;
      if (bus.RD_DATA !== 8'(exp_word)) begin
        n_fail++;
        $display("FAIL drain_data got=%h exp=%h", bus.RD_DATA, 8'(exp_word));
      end
      exp_word++;
      tick();
    end
    idle();
    n_run++;
    if (exp_word != 8'h21 || bus.RD_VALID !== 1'b0 || bus.LEVEL !== 6'd0) begin
      n_fail++;
      $display("FAIL drain_count got words=%0d vld=%b lvl=%0d exp words=33 vld=0 lvl=0",
               exp_word, bus.RD_VALID, bus.LEVEL);
    end
  endtask

  task automatic test_streaming();
    int  exp_word;
    bit  primed;
    int  errs;
    do_reset();
    exp_word = 0;
    primed   = 1'b0;
    errs     = 0;
    bus.RD_READY = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 8'(i);
      tick();
      if (bus.RD_VALID === 1'b1) primed = 1'b1;
      if (primed) begin
        n_run++;
        if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 8'(exp_word) ||
            (bus.LEVEL !== 6'd1 && bus.LEVEL !== 6'd2)) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL stream cyc=%0d got vld=%b data=%h lvl=%0d exp vld=1 data=%h lvl=1..2",
                     i, bus.RD_VALID, bus.RD_DATA, bus.LEVEL, 8'(exp_word));
        end
        exp_word++;
      end
    end
    idle();
    n_run++;
    if (!primed || exp_word < 998) begin
      n_fail++;
      $display("FAIL stream_count got=%0d exp>=998", exp_word);
    end
  endtask

  task automatic test_full_boundary();
    do_reset();
    bus.RD_READY = 1'b0;
    for (int i = 0; i < 33; i++) begin
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 8'(8'h40 + i);
      tick();
    end
    n_run++;
    if (bus.FULL !== 1'b1 || bus.LEVEL !== 6'd33 || bus.OVERFLOW !== 1'b0) begin
      n_fail++;
      $display("FAIL full_reach got full=%b lvl=%0d ovf=%b exp 1/33/0", bus.FULL, bus.LEVEL, bus.OVERFLOW);
    end
    bus.WR_EN    = 1'b1;
    bus.WR_DATA  = 8'hEE;
    bus.RD_READY = 1'b1;
    tick();
    n_run++;
    if (bus.OVERFLOW !== 1'b1 || bus.LEVEL !== 6'd32 || bus.FULL !== 1'b0 || bus.RD_DATA !== 8'h41) begin
      n_fail++;
      $display("FAIL full_pop_write got ovf=%b lvl=%0d full=%b data=%h exp 1/32/0/41",
               bus.OVERFLOW, bus.LEVEL, bus.FULL, bus.RD_DATA);
    end
    bus.RD_READY = 1'b0;
    bus.WR_DATA  = 8'h77;
    tick();
    idle();
    n_run++;
    if (bus.LEVEL !== 6'd33 || bus.FULL !== 1'b1) begin
      n_fail++;
      $display("FAIL full_next_write got lvl=%0d full=%b exp 33/1", bus.LEVEL, bus.FULL);
    end
    bus.RD_READY = 1'b1;
    for (int c = 0; c < 60 && bus.RD_VALID === 1'b1; c++) begin
      n_run++;
      if (bus.RD_DATA !== m_out || m_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain got=%h exp=%h", bus.RD_DATA, m_out);
      end
      tick();
    end
    idle();
    n_run++;
    if (bus.LEVEL !== 6'd0 || m_q.size() != 0 || m_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain_end got lvl=%0d exp 0 (model q=%0d vld=%b)", bus.LEVEL, m_q.size(), m_vld);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 8'(8'h80 + i);
      tick();
    end
    n_run++;
    if (bus.LEVEL !== 6'd17) begin
      n_fail++;
      $display("FAIL mid_level got=%0d exp=17", bus.LEVEL);
    end
    bus.WR_DATA = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (bus.LEVEL !== 6'd0 || bus.RD_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got lvl=%0d vld=%b exp 0/0", bus.LEVEL, bus.RD_VALID);
    end
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = 8'h3C;
    tick();
    idle();
    tick();
    n_run++;
    if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 8'h3C || bus.LEVEL !== 6'd1) begin
      n_fail++;
      $display("FAIL mid_first_word got vld=%b data=%h lvl=%0d exp 1/3c/1",
               bus.RD_VALID, bus.RD_DATA, bus.LEVEL);
    end
  endtask

  task automatic test_random();
    int errs;
    int wr_pct;
    int rd_pct;
    errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wr_pct = (i / 500) % 3 == 0 ? 80 : ((i / 500) % 3 == 1 ? 30 : 55);
      rd_pct = (i / 500) % 3 == 0 ? 30 : ((i / 500) % 3 == 1 ? 80 : 55);
      bus.WR_EN    = ($urandom_range(0, 99) < wr_pct);
      bus.WR_DATA  = c_WIDTH'($urandom);
      bus.RD_READY = ($urandom_range(0, 99) < rd_pct);
      rst          = ($urandom_range(0, 999) == 0);
      tick();
      rst = 1'b0;
      n_run++;
      if (bus.LEVEL !== 6'(m_q.size() + int'(m_vld)) || bus.RD_VALID !== m_vld ||
          bus.FULL !== (m_q.size() == 32) || bus.ALMOST_FULL !== (m_q.size() >= c_AF) ||
          bus.OVERFLOW !== m_ovf || (m_vld && bus.RD_DATA !== m_out)) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random cyc=%0d got lvl=%0d vld=%b data=%h full=%b af=%b ovf=%b exp lvl=%0d vld=%b data=%h full=%b af=%b ovf=%b",
                   i, bus.LEVEL, bus.RD_VALID, bus.RD_DATA, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW,
                   m_q.size() + int'(m_vld), m_vld, m_out, m_q.size() == 32, m_q.size() >= c_AF, m_ovf);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    do_reset();
    test_reset();
    test_latency();
    test_fill_drain();
    test_streaming();
    test_full_boundary();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
